// File: rtl/imm_pkg.sv
// Shared definitions for the immediate encoder/decoder pair: format selects,
// legal immediate ranges and the per-format range check.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_IS = 3'd1,
        IMM_S  = 3'd2,
        IMM_B  = 3'd3,
        IMM_U  = 3'd4,
        IMM_J  = 3'd5
    } imm_sel_e;

    localparam int signed IMM12_MIN = -32'sd2048;
    localparam int signed IMM12_MAX =  32'sd2047;
    localparam int signed IMM13_MIN = -32'sd4096;
    localparam int signed IMM13_MAX =  32'sd4094;
    localparam int signed IMM21_MIN = -32'sd1048576;
    localparam int signed IMM21_MAX =  32'sd1048574;

    // Returns 1 when imm cannot be represented in the format chosen by sel
    // (out of range, misaligned, or an undefined select).
    function automatic logic imm_range_err(input logic [2:0] sel, input logic [31:0] imm);
        logic err;
        case (sel)
            IMM_I, IMM_S: err = ($signed(imm) < IMM12_MIN) || ($signed(imm) > IMM12_MAX);
            IMM_IS:       err = (imm[31:5] != 27'd0);
            IMM_B:        err = ($signed(imm) < IMM13_MIN) || ($signed(imm) > IMM13_MAX) || imm[0];
            IMM_U:        err = (imm[11:0] != 12'd0);
            IMM_J:        err = ($signed(imm) < IMM21_MIN) || ($signed(imm) > IMM21_MAX) || imm[0];
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: scatters imm bits into the format-specific
// instruction fields of a base word. Erroneous requests get zeroed fields.
module imm_pack
    import imm_pkg::*;
(
    input  logic [2:0]  i_sel,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_base,
    input  logic        i_err,
    output logic [31:0] o_instr
);

    logic [31:0] imm_s;

    // Flagged immediates contribute nothing so a bad request cannot leak bits.
    assign imm_s = i_err ? 32'd0 : i_imm;

    // Overlay the immediate fields of the selected format onto the base word.
    always_comb begin
        o_instr = i_base;
        case (i_sel)
            IMM_I:  o_instr[31:20] = imm_s[11:0];
            IMM_IS: o_instr[24:20] = imm_s[4:0];
            IMM_S: begin
                o_instr[31:25] = imm_s[11:5];
                o_instr[11:7]  = imm_s[4:0];
            end
            IMM_B: begin
                o_instr[31]    = imm_s[12];
                o_instr[30:25] = imm_s[10:5];
                o_instr[11:8]  = imm_s[4:1];
                o_instr[7]     = imm_s[11];
            end
            IMM_U:  o_instr[31:12] = imm_s[31:12];
            IMM_J: begin
                o_instr[31]    = imm_s[20];
                o_instr[30:21] = imm_s[10:1];
                o_instr[20]    = imm_s[11];
                o_instr[19:12] = imm_s[19:12];
            end
            default: o_instr = i_base;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: two-stage valid/ready pipeline that range-checks and packs
// immediates into instruction words, tagging each with a sequential IMEM address.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int                  P_ADDR_W    = 32,
    parameter logic [P_ADDR_W-1:0] P_BASE_ADDR = '0,
    parameter int                  P_ERRCNT_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_imm_sel,
    input  logic [31:0]           i_imm,
    input  logic [31:0]           i_base,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [31:0]           o_instr,
    output logic [P_ADDR_W-1:0]   o_addr,
    output logic                  o_err,
    output logic [P_ERRCNT_W-1:0] o_err_cnt
);

    localparam logic [P_ERRCNT_W-1:0] CNT_MAX = {P_ERRCNT_W{1'b1}};

    // Stage 1: captured request plus its range-check verdict.
    logic                  s1_valid_q, s1_valid_d;
    logic [2:0]            s1_sel_q,   s1_sel_d;
    logic [31:0]           s1_imm_q,   s1_imm_d;
    logic [31:0]           s1_base_q,  s1_base_d;
    logic                  s1_err_q,   s1_err_d;
    // Stage 2: packed word presented on the output.
    logic                  s2_valid_q, s2_valid_d;
    logic [31:0]           instr_q,    instr_d;
    logic                  err_q,      err_d;
    // Address and error bookkeeping.
    logic [P_ADDR_W-1:0]   addr_q,     addr_d;
    logic [P_ERRCNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic        s2_ready_s;
    logic        s1_move_s;
    logic        accept_s;
    logic        out_hs_s;
    logic [31:0] packed_s;

    imm_pack u_pack (
        .i_sel   (s1_sel_q),
        .i_imm   (s1_imm_q),
        .i_base  (s1_base_q),
        .i_err   (s1_err_q),
        .o_instr (packed_s)
    );

    // Handshake: a stage may load when it is empty or its content leaves this cycle.
    assign s2_ready_s = !s2_valid_q || i_ready;
    assign s1_move_s  = s1_valid_q && s2_ready_s;
    assign o_ready    = !s1_valid_q || s2_ready_s;
    assign accept_s   = i_valid && o_ready;
    assign out_hs_s   = s2_valid_q && i_ready;

    // Next-state for stage 1: take a new request, empty on move-out, else hold.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sel_d   = s1_sel_q;
        s1_imm_d   = s1_imm_q;
        s1_base_d  = s1_base_q;
        s1_err_d   = s1_err_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_sel_d   = i_imm_sel;
            s1_imm_d   = i_imm;
            s1_base_d  = i_base;
            s1_err_d   = imm_range_err(i_imm_sel, i_imm);
        end else if (s1_move_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Next-state for stage 2: data only changes when a word moves in, so a
    // stalled output stays stable.
    always_comb begin
        s2_valid_d = s2_valid_q;
        instr_d    = instr_q;
        err_d      = err_q;
        if (s2_ready_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (s1_move_s) begin
            instr_d = packed_s;
            err_d   = s1_err_q;
        end else begin
            instr_d = instr_q;
            err_d   = err_q;
        end
    end

    // Next-state for address and saturating error counter; clear beats handshake.
    always_comb begin
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        if (i_clr) begin
            addr_d    = P_BASE_ADDR;
            err_cnt_d = {P_ERRCNT_W{1'b0}};
        end else if (out_hs_s) begin
            addr_d = addr_q + P_ADDR_W'(32'd4);
            if (err_q && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + P_ERRCNT_W'(1'b1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            addr_d    = addr_q;
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers with synchronous active-low reset dropping in-flight words.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sel_q   <= 3'd0;
            s1_imm_q   <= 32'd0;
            s1_base_q  <= 32'd0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            instr_q    <= 32'd0;
            err_q      <= 1'b0;
            addr_q     <= P_BASE_ADDR;
            err_cnt_q  <= {P_ERRCNT_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sel_q   <= s1_sel_d;
            s1_imm_q   <= s1_imm_d;
            s1_base_q  <= s1_base_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            instr_q    <= instr_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_valid   = s2_valid_q;
    assign o_instr   = instr_q;
    assign o_err     = err_q;
    assign o_addr    = addr_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: a vector table for packing/range rules, then
// hand-written sequences for clear, backpressure, counter saturation and reset.
module tb_imm_encoder;

    logic        clk;
    logic        i_rst_n;
    logic        i_clr;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_imm_sel;
    logic [31:0] i_imm;
    logic [31:0] i_base;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [31:0] o_addr;
    logic        o_err;
    logic [7:0]  o_err_cnt;

    int compared   = 0;
    int mismatched = 0;
    int accepted   = 0;

    logic [31:0] exp_addr;
    logic [7:0]  exp_cnt;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t vecs [17];

    imm_encoder dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (i_clr),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_imm_sel (i_imm_sel),
        .i_imm     (i_imm),
        .i_base    (i_base),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_instr   (o_instr),
        .o_addr    (o_addr),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called on a negedge; holds the request until it is accepted, returns on the next negedge.
    task automatic push(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
        int n;
        n = 0;
        i_valid   = 1'b1;
        i_imm_sel = sel;
        i_imm     = imm;
        i_base    = base;
        forever begin
            #4;
            if (o_ready) break;
            n++;
            if (n >= 50) break;
            @(negedge clk);
        end
        chk("push_timeout", {31'd0, (n >= 50)}, 32'd0);
        if (n < 50) accepted++;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Waits (bounded) for o_valid; returns the number of extra negedges waited.
    task automatic wait_valid(output int n);
        n = 0;
        #1;
        while (!o_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("out_timeout", {31'd0, (n >= 20)}, 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] w_exp [4];

        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0};
        vecs[1]  = '{3'd1, 32'h0000_0003, 32'h4000_5013, 32'h4030_5013, 1'b0};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0};
        vecs[3]  = '{3'd5, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0};
        vecs[4]  = '{3'd4, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0};
        vecs[5]  = '{3'd0, 32'h0000_0800, 32'hABC0_0013, 32'h0000_0013, 1'b1};
        vecs[6]  = '{3'd3, 32'h0000_0003, 32'h0000_0063, 32'h0000_0063, 1'b1};
        vecs[7]  = '{3'd7, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        vecs[8]  = '{3'd2, 32'hFFFF_F800, 32'h0000_2023, 32'h8000_2023, 1'b0};
        vecs[9]  = '{3'd1, 32'h0000_0020, 32'h40F0_5013, 32'h4000_5013, 1'b1};
        vecs[10] = '{3'd4, 32'h1234_5001, 32'hFFFF_F037, 32'h0000_0037, 1'b1};
        vecs[11] = '{3'd5, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0};
        vecs[12] = '{3'd5, 32'h0010_0000, 32'h0000_006F, 32'h0000_006F, 1'b1};
        vecs[13] = '{3'd3, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0};
        vecs[14] = '{3'd2, 32'h0000_07FF, 32'h0000_0023, 32'h7E00_0FA3, 1'b0};
        vecs[15] = '{3'd6, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1};
        vecs[16] = '{3'd0, 32'hFFFF_F7FF, 32'h0000_0013, 32'h0000_0013, 1'b1};

        i_rst_n = 1'b0; i_clr = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_imm_sel = 3'd0; i_imm = 32'd0; i_base = 32'd0;
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o_instr", o_instr, 32'd0);
        chk("rst_o_err",   {31'd0, o_err}, 32'd0);
        chk("rst_o_addr",  o_addr, 32'd0);
        chk("rst_err_cnt", {24'd0, o_err_cnt}, 32'd0);
        chk("rst_o_ready", {31'd0, o_ready}, 32'd1);
        @(negedge clk);

        // Table: one word at a time, downstream always ready.
        exp_addr = 32'd0;
        exp_cnt  = 8'd0;
        for (int i = 0; i < 17; i++) begin
            push(vecs[i].sel, vecs[i].imm, vecs[i].base);
            wait_valid(n);
            chk($sformatf("v%0d_latency", i), n, 32'd1);
            chk($sformatf("v%0d_instr", i), o_instr, vecs[i].exp_instr);
            chk($sformatf("v%0d_err", i), {31'd0, o_err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_addr", i), o_addr, exp_addr);
            chk($sformatf("v%0d_cnt", i), {24'd0, o_err_cnt}, {24'd0, exp_cnt});
            @(negedge clk);
            exp_addr = exp_addr + 32'd4;
            if (vecs[i].exp_err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        end

        // Clear coinciding with an error-word handshake: clear wins.
        push(3'd6, 32'd0, 32'h0000_0013);
        wait_valid(n);
        chk("clr_pre_addr", o_addr, exp_addr);
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        #1;
        chk("clr_addr",    o_addr, 32'd0);
        chk("clr_cnt",     {24'd0, o_err_cnt}, 32'd0);
        chk("clr_drained", {31'd0, o_valid}, 32'd0);
        @(negedge clk);

        // Backpressure: 4 back-to-back requests, downstream stalled 5 cycles.
        for (int j = 0; j < 4; j++) w_exp[j] = 32'h0000_0013 | ((j + 1) << 20);
        accepted = 0;
        i_ready  = 1'b0;
        fork
            begin
                for (int j = 0; j < 4; j++) push(3'd0, j + 1, 32'h0000_0013);
            end
            begin
                @(negedge clk);
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    #2;
                    chk($sformatf("bp_stall%0d_ready", c), {31'd0, o_ready}, 32'd0);
                    chk($sformatf("bp_stall%0d_valid", c), {31'd0, o_valid}, 32'd1);
                    chk($sformatf("bp_stall%0d_instr", c), o_instr, w_exp[0]);
                end
                chk("bp_accepted", accepted, 32'd2);
                i_ready = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    int m;
                    m = 0;
                    while (!o_valid && m < 20) begin
                        @(negedge clk);
                        #1;
                        m++;
                    end
                    chk($sformatf("bp_w%0d_instr", j), o_instr, w_exp[j]);
                    chk($sformatf("bp_w%0d_addr", j), o_addr, 32'(j * 4));
                    @(negedge clk);
                    #1;
                end
            end
        join
        @(negedge clk);
        #1;
        chk("bp_empty", {31'd0, o_valid}, 32'd0);
        @(negedge clk);

        // Error counter saturation: 300 illegal-select words.
        for (int k = 0; k < 300; k++) push(3'd7, 32'd0, 32'h0000_0013);
        repeat (5) @(negedge clk);
        #1;
        chk("sat_cnt",   {24'd0, o_err_cnt}, 32'h0000_00FF);
        chk("sat_addr",  o_addr, 32'd16 + 32'd1200);
        chk("sat_empty", {31'd0, o_valid}, 32'd0);
        @(negedge clk);

        // Reset while a word is held on the output.
        i_ready = 1'b0;
        push(3'd0, 32'd1, 32'h0000_0013);
        wait_valid(n);
        chk("rst2_pre_valid", {31'd0, o_valid}, 32'd1);
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        chk("rst2_valid", {31'd0, o_valid}, 32'd0);
        chk("rst2_instr", o_instr, 32'd0);
        chk("rst2_addr",  o_addr, 32'd0);
        chk("rst2_cnt",   {24'd0, o_err_cnt}, 32'd0);
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst2_no_ghost", {31'd0, o_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
